// File: rtl/div64x32_pkg.sv
// Shared types and width constants for the 64/32 restoring divider.
package div64x32_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int DIV_ITER   = 32;
    localparam int DIVIDEND_W = 64;
    localparam int DIVISOR_W  = 32;
    localparam int REM_W      = 33;
    localparam int CNT_W      = 5;

endpackage

// File: rtl/div64x32_fsm.sv
// Control for the divider: IDLE/CALC state, iteration counter, and the
// load/step/done strobes that drive the datapath.
module div64x32_fsm
    import div64x32_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic load,
    output logic step,
    output logic done
);

    state_t state;
    state_t next_state;
    logic [CNT_W-1:0] count;
    logic last_iter;

    assign last_iter = (count == CNT_W'(DIV_ITER - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            if (load)
                count <= '0;
            else if (step)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_iter) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/div64x32.sv
// 64-by-32 unsigned restoring divider: one quotient bit per cycle, fixed
// 32-cycle calculation, registered results with divide-by-zero/overflow flags.
module div64x32
    import div64x32_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    logic load;
    logic step;
    logic done;

    logic [REM_W-1:0]     r_reg;
    logic [DIVISOR_W-1:0] q_reg;
    logic [DIVISOR_W-1:0] dvsr_reg;
    logic                 dz_pend;
    logic                 ov_pend;
    logic                 err_pend;

    logic [REM_W-1:0]     shifted;
    logic [REM_W-1:0]     dvsr_ext;
    logic                 fits;
    logic [REM_W-1:0]     r_next;
    logic [DIVISOR_W-1:0] q_next;

    div64x32_fsm u_fsm (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .load  (load),
        .step  (step),
        .done  (done)
    );

    assign err_pend = dz_pend | ov_pend;

    // The bit shifted out of R's top is folded into the compare so a
    // 34-bit shifted value is handled without widening the subtractor.
    always_comb begin
        shifted  = {r_reg[REM_W-2:0], q_reg[DIVISOR_W-1]};
        dvsr_ext = {1'b0, dvsr_reg};
        fits     = r_reg[REM_W-1] | (shifted >= dvsr_ext);
        r_next   = fits ? (shifted - dvsr_ext) : shifted;
        q_next   = {q_reg[DIVISOR_W-2:0], fits};
    end

    // Error cases freeze R/Q so Q still holds dividend[31:0] for the remainder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg       <= '0;
            q_reg       <= '0;
            dvsr_reg    <= '0;
            dz_pend     <= 1'b0;
            ov_pend     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (load) begin
                r_reg    <= {1'b0, dividend[DIVIDEND_W-1:DIVISOR_W]};
                q_reg    <= dividend[DIVISOR_W-1:0];
                dvsr_reg <= divisor;
                dz_pend  <= (divisor == '0);
                ov_pend  <= (divisor != '0) && (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor);
            end else if (step && !err_pend) begin
                r_reg <= r_next;
                q_reg <= q_next;
            end

            if (done) begin
                if (err_pend) begin
                    quotient  <= '1;
                    remainder <= q_reg;
                end else begin
                    quotient  <= q_next;
                    remainder <= r_next[DIVISOR_W-1:0];
                end
                div_by_zero <= dz_pend;
                overflow    <= ov_pend;
            end
        end
    end

endmodule

// File: tb/tb_div64x32.sv
// Scoreboard bench for div64x32: stimulus pushes expected results, a monitor
// pops and compares whenever busy falls.
module tb_div64x32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic busy_d    = 1'b0;

    div64x32 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a result is presented in the first idle cycle after busy falls.
    always @(negedge clk) begin
        if (reset) begin
            busy_d <= 1'b0;
        end else begin
            if (busy_d && !busy) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_result", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("quotient",    {32'd0, quotient},  {32'd0, mon_e.q});
                    check_output("remainder",   {32'd0, remainder}, {32'd0, mon_e.r});
                    check_output("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.dz});
                    check_output("overflow",    {63'd0, overflow},  {63'd0, mon_e.ov});
                end
            end
            busy_d <= busy;
        end
    end

    function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ov);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        e.ov = ov;
        return e;
    endfunction

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100)
            check_output("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [63:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clk);
        #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(e);
        @(negedge clk);
        #1;
        start = 1'b0;
        check_output("busy_rise", {63'd0, busy}, 64'd1);
    endtask

    // Full division: start cycle plus 32 busy cycles gives a 33-cycle latency.
    task automatic apply_stimulus(input string name, input logic [63:0] a, input logic [31:0] b, input exp_t e);
        int cyc;
        issue(a, b, e);
        wait_idle(cyc);
        check_output({name, "_latency"}, 64'(cyc + 1), 64'd33);
    endtask

    initial begin
        int cyc;
        logic [31:0] rb, rhi;
        logic [63:0] ra;
        int n_b2b;
        n_b2b = 200;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check_output("reset_busy",  {63'd0, busy}, 64'd0);
        check_output("reset_quot",  {32'd0, quotient}, 64'd0);
        check_output("reset_rem",   {32'd0, remainder}, 64'd0);
        check_output("reset_flags", {62'd0, div_by_zero, overflow}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;

        apply_stimulus("basic",   64'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0));
        apply_stimulus("maximum", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0));
        apply_stimulus("divzero", 64'h1234, 32'd0, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0));
        apply_stimulus("overflow", 64'h1_0000_0005, 32'd1, mk(32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1));
        apply_stimulus("after_ov", 64'd50, 32'd5, mk(32'd10, 32'd0, 1'b0, 1'b0));
        apply_stimulus("ov_equal", 64'h7_0000_0000, 32'd7, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1));
        apply_stimulus("edge_fit", 64'h6_FFFF_FFFF, 32'd7, mk(32'hFFFF_FFFF, 32'd6, 1'b0, 1'b0));
        apply_stimulus("small_q",  64'd6, 32'd7, mk(32'd0, 32'd6, 1'b0, 1'b0));

        // Start with new operands mid-calculation must be ignored.
        issue(64'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0));
        repeat (9) @(negedge clk);
        #1;
        start    = 1'b1;
        dividend = 64'd999;
        divisor  = 32'd3;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle(cyc);
        check_output("ignored_start_latency", 64'(cyc + 11), 64'd33);

        // Reset mid-calculation aborts with nothing visible.
        issue(64'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0));
        repeat (19) @(negedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        check_output("abort_busy",  {63'd0, busy}, 64'd0);
        check_output("abort_quot",  {32'd0, quotient}, 64'd0);
        check_output("abort_rem",   {32'd0, remainder}, 64'd0);
        check_output("abort_flags", {62'd0, div_by_zero, overflow}, 64'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus("post_reset", 64'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0));

        // Back-to-back random divisions with start held high.
        @(negedge clk);
        #1;
        rb = $urandom;
        if (rb == 0) rb = 32'd1;
        rhi = $urandom_range(rb - 1, 0);
        ra  = {rhi, 32'($urandom)};
        start    = 1'b1;
        dividend = ra;
        divisor  = rb;
        sb.push_back(mk(32'(ra / {32'd0, rb}), 32'(ra % {32'd0, rb}), 1'b0, 1'b0));
        for (int i = 0; i < n_b2b; i++) begin
            @(negedge clk);
            check_output("b2b_busy_gap", {63'd0, busy}, 64'd1);
            #1;
            if (i < n_b2b - 1) begin
                rb = $urandom;
                if (rb == 0) rb = 32'd1;
                rhi = $urandom_range(rb - 1, 0);
                ra  = {rhi, 32'($urandom)};
                dividend = ra;
                divisor  = rb;
                sb.push_back(mk(32'(ra / {32'd0, rb}), 32'(ra % {32'd0, rb}), 1'b0, 1'b0));
            end else begin
                start = 1'b0;
            end
            wait_idle(cyc);
        end

        repeat (2) @(negedge clk);
        check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
